conv_window_sequencer: RTL and testbench

//  Drives the SIZE x SIZE kernel/pixel indexer (cur_x, cur_y, en_strobe) through one full

---
 rtl/conv_window_sequencer_pkg.sv | 20 ++
 rtl/conv_window_sequencer_if.sv | 34 +++
 rtl/conv_window_sequencer_mac_accum.sv | 34 +++
 rtl/conv_window_sequencer.sv | 117 +++++++++++
 tb/tb_conv_window_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_window_sequencer_pkg.sv
// Shared types and widths for the convolution window sequencer.
package conv_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    localparam int PIX_W  = 8;
    localparam int IDX_W  = 4;
    localparam int PROD_W = 16;

    // True when an index sits on the last position of a window edge of length size.
    function automatic logic idx_last(input logic [IDX_W-1:0] idx, input logic [IDX_W-1:0] size);
        return idx == (size - {{(IDX_W-1){1'b0}}, 1'b1});
    endfunction

endpackage

// File: rtl/conv_window_sequencer_if.sv
// Handshake and data bundle between the sequencer, its indexer and the downstream stage.
interface conv_window_sequencer_if
    import conv_seq_pkg::*;
#(
    parameter int ACC_W = 24
) ();

    logic               start;
    logic               start_ready;
    logic               abort;
    logic [IDX_W-1:0]   cur_x;
    logic [IDX_W-1:0]   cur_y;
    logic               en_strobe;
    logic [PIX_W-1:0]   pixel_v;
    logic [PIX_W-1:0]   kernel_v;
    logic [ACC_W-1:0]   result;
    logic [PIX_W-1:0]   norm_pixel;
    logic               result_valid;
    logic               result_ready;
    logic               busy;

    // Sequencer side.
    modport slave (
        input  start, abort, pixel_v, kernel_v, result_ready,
        output start_ready, cur_x, cur_y, en_strobe, result, norm_pixel, result_valid, busy
    );

    // Scheduler / indexer / downstream side.
    modport master (
        output start, abort, pixel_v, kernel_v, result_ready,
        input  start_ready, cur_x, cur_y, en_strobe, result, norm_pixel, result_valid, busy
    );

endinterface

// File: rtl/conv_window_sequencer_mac_accum.sv
// Multiply-accumulate register: acc += a*b when en, cleared to zero by clear.
module mac_accum
    import conv_seq_pkg::*;
#(
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             en,
    input  logic [PIX_W-1:0] a,
    input  logic [PIX_W-1:0] b,
    output logic [ACC_W-1:0] acc
);

    logic [PROD_W-1:0] prod;
    logic [ACC_W-1:0]  acc_reg;

    // 8x8 unsigned product always fits 16 bits; zero-extended before the add.
    assign prod = PROD_W'(a) * PROD_W'(b);
    assign acc  = acc_reg;

    // Accumulator register; clear wins over a simultaneous enable.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            acc_reg <= '0;
        end else if (clear) begin
            acc_reg <= '0;
        end else if (en) begin
            acc_reg <= acc_reg + ACC_W'(prod);
        end
    end

endmodule

// File: rtl/conv_window_sequencer.sv
// Walks a SIZE x SIZE window through the indexer, accumulates the returned
// pixel*weight pairs and offers the sum on a valid/ready output.
module conv_window_sequencer
    import conv_seq_pkg::*;
#(
    parameter logic [3:0] SIZE         = 4'd3,
    parameter int         ACC_W        = 24,
    parameter int         RESULT_SHIFT = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    conv_window_sequencer_if.slave  bus
);

    seq_state_t        state_reg, state_next;
    logic [IDX_W-1:0]  x_reg, x_next;
    logic [IDX_W-1:0]  y_reg, y_next;
    logic              acc_en_reg;
    logic              acc_clear;
    logic              en_strobe;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  shifted;

    // Indexer strobes throughout ISSUE; its data comes back one cycle later.
    assign en_strobe = (state_reg == ISSUE);

    // State, index counters and the delayed strobe that qualifies returning data.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg  <= IDLE;
            x_reg      <= '0;
            y_reg      <= '0;
            acc_en_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            x_reg      <= x_next;
            y_reg      <= y_next;
            acc_en_reg <= en_strobe & ~bus.abort;
        end
    end

    // Next-state and index stepping; abort overrides everything else.
    always_comb begin
        state_next = state_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        acc_clear  = 1'b0;
        if (bus.abort) begin
            state_next = IDLE;
            x_next     = '0;
            y_next     = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        state_next = ISSUE;
                        acc_clear  = 1'b1;
                        x_next     = '0;
                        y_next     = '0;
                    end
                end
                ISSUE: begin
                    if (idx_last(x_reg, SIZE)) begin
                        x_next = '0;
                        if (idx_last(y_reg, SIZE)) begin
                            y_next     = '0;
                            state_next = DRAIN;
                        end else begin
                            y_next = y_reg + 4'd1;
                        end
                    end else begin
                        x_next = x_reg + 4'd1;
                    end
                end
                DRAIN: begin
                    // The last pair arrives in this cycle and is folded in on this edge.
                    state_next = DONE;
                end
                DONE: begin
                    if (bus.result_ready) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    mac_accum #(
        .ACC_W (ACC_W)
    ) u_mac (
        .clk   (clk),
        .n_rst (n_rst),
        .clear (acc_clear),
        .en    (acc_en_reg & ~bus.abort),
        .a     (bus.pixel_v),
        .b     (bus.kernel_v),
        .acc   (acc)
    );

    assign shifted = acc >> RESULT_SHIFT;

    // Output decode: handshake flags from state, normalised pixel saturates at 255.
    always_comb begin
        bus.start_ready  = (state_reg == IDLE);
        bus.busy         = (state_reg != IDLE);
        bus.result_valid = (state_reg == DONE);
        bus.en_strobe    = en_strobe;
        bus.cur_x        = x_reg;
        bus.cur_y        = y_reg;
        bus.result       = acc;
        bus.norm_pixel   = (shifted > ACC_W'(255)) ? 8'hFF : shifted[PIX_W-1:0];
    end

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Self-checking bench: table vectors, hand-written corner sequences and
// randomized windows checked against a sum-of-products reference.
module tb_conv_window_sequencer;
    import conv_seq_pkg::*;

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    conv_window_sequencer_if #(.ACC_W(24)) bus3 ();
    conv_window_sequencer_if #(.ACC_W(24)) bus1 ();

    conv_window_sequencer #(.SIZE(4'd3), .ACC_W(24), .RESULT_SHIFT(4)) dut3 (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus3)
    );

    conv_window_sequencer #(.SIZE(4'd1), .ACC_W(24), .RESULT_SHIFT(4)) dut1 (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus1)
    );

    // Window contents presented by the modelled indexer.
    logic [7:0] pix3 [16][16];
    logic [7:0] ker3 [16][16];
    logic [7:0] pix1, ker1;
    logic       ld3, ld1;
    logic [7:0] pend3_p, pend3_k;
    logic [7:0] slog [$];

    int n_vec = 0;
    int n_bad = 0;

    // Indexer model: capture the strobed address away from the edge, register data on the edge.
    always @(negedge clk) begin
        ld3 = bus3.en_strobe;
        ld1 = bus1.en_strobe;
        if (bus3.en_strobe) begin
            pend3_p = pix3[bus3.cur_y][bus3.cur_x];
            pend3_k = ker3[bus3.cur_y][bus3.cur_x];
            slog.push_back({bus3.cur_x, bus3.cur_y});
        end
    end

    always @(posedge clk) begin
        if (ld3) begin
            bus3.pixel_v  <= pend3_p;
            bus3.kernel_v <= pend3_k;
        end
        if (ld1) begin
            bus1.pixel_v  <= pix1;
            bus1.kernel_v <= ker1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain sum of products over the 3x3 window.
    function automatic longint model_sum();
        longint s = 0;
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 3; x++)
                s += longint'(pix3[y][x]) * longint'(ker3[y][x]);
        return s;
    endfunction

    function automatic longint model_norm(input longint s);
        return ((s >> 4) > 255) ? 255 : (s >> 4);
    endfunction

    task automatic fill3(input logic [7:0] p, input logic [7:0] k);
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++) begin
                pix3[y][x] = p;
                ker3[y][x] = k;
            end
    endtask

    task automatic start3();
        @(negedge clk);
        bus3.start = 1'b1;
        @(posedge clk);
        #1 bus3.start = 1'b0;
    endtask

    // Counts edges after the start edge until one samples result_valid high; 0 on timeout.
    task automatic wait_valid3(output int lat);
        logic v;
        lat = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            v = bus3.result_valid;
            @(posedge clk);
            if (v) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic run3(input int ready_delay, output int lat, output logic [23:0] res,
                        output logic [7:0] norm, output int nstrobe, output bit order_ok);
        int idx;
        slog.delete();
        start3();
        wait_valid3(lat);
        @(negedge clk);
        res  = bus3.result;
        norm = bus3.norm_pixel;
        repeat (ready_delay) @(negedge clk);
        bus3.result_ready = 1'b1;
        @(posedge clk);
        #1 bus3.result_ready = 1'b0;
        nstrobe  = slog.size();
        order_ok = 1'b1;
        idx      = 0;
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 3; x++) begin
                logic [7:0] e;
                e = {4'(x), 4'(y)};
                if (idx >= slog.size() || slog[idx] != e) order_ok = 1'b0;
                idx++;
            end
    endtask

    typedef struct {
        logic [7:0]  pix_all;
        logic [7:0]  ker_all;
        bit          center;
        logic [7:0]  c_pix;
        logic [7:0]  c_ker;
        logic [23:0] exp_res;
        logic [7:0]  exp_norm;
    } vec_t;

    vec_t tbl [5];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, ns;
        logic [23:0] res;
        logic [7:0]  nrm;
        bit          ok, seen;
        int          k;

        tbl[0] = '{8'd1,   8'd1,   1'b0, 8'd0,   8'd0,  24'd9,      8'd0};
        tbl[1] = '{8'd255, 8'd255, 1'b0, 8'd0,   8'd0,  24'd585225, 8'd255};
        tbl[2] = '{8'd5,   8'd0,   1'b1, 8'd200, 8'd16, 24'd3200,   8'd200};
        tbl[3] = '{8'd2,   8'd3,   1'b0, 8'd0,   8'd0,  24'd54,     8'd3};
        tbl[4] = '{8'd100, 8'd50,  1'b0, 8'd0,   8'd0,  24'd45000,  8'd255};

        n_rst = 1'b0;
        bus3.start = 0; bus3.abort = 0; bus3.result_ready = 0; bus3.pixel_v = 0; bus3.kernel_v = 0;
        bus1.start = 0; bus1.abort = 0; bus1.result_ready = 0; bus1.pixel_v = 0; bus1.kernel_v = 0;
        ld3 = 0; ld1 = 0; pend3_p = 0; pend3_k = 0;
        pix1 = 0; ker1 = 0;
        fill3(8'd0, 8'd0);

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_valid", bus3.result_valid, 0);
        chk("rst_busy", bus3.busy, 0);
        chk("rst_strobe", bus3.en_strobe, 0);
        chk("rst_result", bus3.result, 0);
        chk("rst_start_ready", bus3.start_ready, 1);
        chk("rst_idx", {bus3.cur_x, bus3.cur_y}, 0);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven windows.
        for (int i = 0; i < 5; i++) begin
            fill3(tbl[i].pix_all, tbl[i].ker_all);
            if (tbl[i].center) begin
                pix3[1][1] = tbl[i].c_pix;
                ker3[1][1] = tbl[i].c_ker;
            end
            run3(0, lat, res, nrm, ns, ok);
            $display("vec %0d: result=%0d norm=%0d latency=%0d strobes=%0d", i, res, nrm, lat, ns);
            chk($sformatf("tbl%0d_result", i), res, tbl[i].exp_res);
            chk($sformatf("tbl%0d_norm", i), nrm, tbl[i].exp_norm);
            chk($sformatf("tbl%0d_latency", i), lat, 11);
            chk($sformatf("tbl%0d_strobes", i), ns, 9);
            chk($sformatf("tbl%0d_order", i), ok, 1);
            @(negedge clk);
            chk($sformatf("tbl%0d_idle", i), bus3.busy, 0);
        end

        // Back-pressure: hold ready low in DONE, starts must be ignored.
        fill3(8'd1, 8'd1);
        start3();
        wait_valid3(lat);
        chk("bp_latency", lat, 11);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", bus3.result_valid, 1);
            chk("bp_result", bus3.result, 9);
            chk("bp_start_ready", bus3.start_ready, 0);
            bus3.start = 1'b1;
            @(posedge clk);
            #1 bus3.start = 1'b0;
        end
        @(negedge clk);
        bus3.result_ready = 1'b1;
        @(posedge clk);
        #1 bus3.result_ready = 1'b0;
        @(negedge clk);
        chk("bp_release_valid", bus3.result_valid, 0);
        chk("bp_release_busy", bus3.busy, 0);
        @(negedge clk);
        chk("bp_no_restart", bus3.en_strobe, 0);
        $display("backpressure: window accepted after 5 held cycles");

        // Abort on the 4th strobe.
        fill3(8'd1, 8'd1);
        start3();
        k = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus3.en_strobe) k++;
            if (k == 4) begin
                bus3.abort = 1'b1;
                break;
            end
        end
        chk("abort_reached_4th", k, 4);
        @(posedge clk);
        #1 bus3.abort = 1'b0;
        @(negedge clk);
        chk("abort_strobe", bus3.en_strobe, 0);
        chk("abort_busy", bus3.busy, 0);
        seen = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (bus3.result_valid) seen = 1'b1;
        end
        chk("abort_no_valid", seen, 0);
        run3(1, lat, res, nrm, ns, ok);
        $display("after abort: result=%0d latency=%0d", res, lat);
        chk("abort_next_result", res, 9);
        chk("abort_next_latency", lat, 11);

        // Randomized windows against the reference model.
        for (int r = 0; r < 8; r++) begin
            int d;
            for (int y = 0; y < 3; y++)
                for (int x = 0; x < 3; x++) begin
                    pix3[y][x] = 8'($urandom_range(0, 255));
                    ker3[y][x] = (r % 3 == 0) ? 8'd255 : 8'($urandom_range(0, 31));
                end
            d = $urandom_range(0, 3);
            run3(d, lat, res, nrm, ns, ok);
            $display("rand %0d: result=%0d norm=%0d latency=%0d", r, res, nrm, lat);
            chk($sformatf("rand%0d_result", r), res, model_sum());
            chk($sformatf("rand%0d_norm", r), nrm, model_norm(model_sum()));
            chk($sformatf("rand%0d_latency", r), lat, 11);
        end

        // Asynchronous reset in the middle of ISSUE.
        fill3(8'd1, 8'd1);
        start3();
        repeat (3) @(negedge clk);
        n_rst = 1'b0;
        #1;
        chk("mid_rst_strobe", bus3.en_strobe, 0);
        chk("mid_rst_busy", bus3.busy, 0);
        chk("mid_rst_valid", bus3.result_valid, 0);
        chk("mid_rst_result", bus3.result, 0);
        chk("mid_rst_idx", {bus3.cur_x, bus3.cur_y}, 0);
        chk("mid_rst_start_ready", bus3.start_ready, 1);
        @(negedge clk);
        n_rst = 1'b1;
        $display("mid-scan reset applied");

        // SIZE=1 window.
        pix1 = 8'd7;
        ker1 = 8'd3;
        @(negedge clk);
        bus1.start = 1'b1;
        @(posedge clk);
        #1 bus1.start = 1'b0;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            logic v;
            @(negedge clk);
            v = bus1.result_valid;
            @(posedge clk);
            if (v) begin
                lat = c;
                break;
            end
        end
        @(negedge clk);
        $display("size1: result=%0d norm=%0d latency=%0d", bus1.result, bus1.norm_pixel, lat);
        chk("size1_latency", lat, 3);
        chk("size1_result", bus1.result, 21);
        chk("size1_norm", bus1.norm_pixel, 1);
        bus1.result_ready = 1'b1;
        @(posedge clk);
        #1 bus1.result_ready = 1'b0;
        @(negedge clk);
        chk("size1_idle", bus1.busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
